// File: rtl/sram_sp_bist_ctrl.sv
// rtl/sram_sp_bist_ctrl.sv - March C- BIST controller driving a single-port byte-enabled SRAM
// Define SRAM_BIST_DIAG_EN to capture FAIL_ADDR/FAIL_DATA at the first mismatch.
module sram_sp_bist_ctrl #(
   parameter int AW = 14,
   parameter int DW = 32
) (
   input  logic            CLK,
   input  logic            RESETn,
   input  logic            START,
   output logic            BUSY,
   output logic            DONE,
   output logic            FAIL,
   output logic [AW-1:0]   FAIL_ADDR,
   output logic [DW-1:0]   FAIL_DATA,
   output logic            CEN,
   output logic [DW/8-1:0] BEN,
   output logic            GWEN,
   output logic [AW-1:0]   A,
   output logic [DW-1:0]   D,
   input  logic [DW-1:0]   Q
);

   typedef enum logic [3:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_END
   } state_t;

   localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
   localparam logic [AW-1:0] ADDR_LAST = '1;

   state_t          state, state_nx;
   logic [AW-1:0]   addr, addr_nx;
   logic            phase, phase_nx;
   logic            elem_last, two_op, cur_read, mismatch, start_run;
   logic            cmp_valid, fail_r;
   logic [DW-1:0]   cmp_exp;
   logic            cen_r, gwen_r, cen_nx, gwen_nx, wr_nx, act_nx;
   logic [DW/8-1:0] ben_r, ben_nx;
   logic [AW-1:0]   a_r, a_nx;
   logic [DW-1:0]   d_r, d_nx;

   function automatic logic is_march(input state_t s);
      return s inside {[S_M0:S_M5]};
   endfunction

   function automatic logic is_desc(input state_t s);
      return (s == S_M3) || (s == S_M4);
   endfunction

   function automatic logic op_write(input state_t s, input logic ph);
      case (s)
         S_M0:                   return 1'b1;
         S_M1, S_M2, S_M3, S_M4: return ph;
         default:                return 1'b0;
      endcase
   endfunction

   // Background for the op: write data for writes, expected value for reads.
   function automatic logic [DW-1:0] op_data(input state_t s, input logic ph);
      logic [DW-1:0] ones;
      ones = '1;
      case (s)
         S_M1, S_M3: return ph ? ones : '0;
         S_M2, S_M4: return ph ? '0 : ones;
         default:    return '0;
      endcase
   endfunction

   assign two_op    = state inside {[S_M1:S_M4]};
   assign elem_last = is_desc(state) ? (addr == '0) : (addr == ADDR_LAST);
   assign cur_read  = is_march(state) && !op_write(state, phase);
   assign mismatch  = cmp_valid && (Q != cmp_exp);
   assign start_run = ((state == S_IDLE) || (state == S_END)) && START;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state <= S_IDLE;
         addr  <= '0;
         phase <= 1'b0;
      end else begin
         state <= state_nx;
         addr  <= addr_nx;
         phase <= phase_nx;
      end
   end

   always_comb begin
      state_nx = state;
      addr_nx  = addr;
      phase_nx = phase;
      case (state)
         S_IDLE, S_END: begin
            if (START) begin
               state_nx = S_M0;
               addr_nx  = '0;
               phase_nx = 1'b0;
            end
         end
         S_FLUSH: state_nx = S_END;
         default: begin
            if (two_op && !phase) begin
               phase_nx = 1'b1;
            end else begin
               phase_nx = 1'b0;
               if (elem_last) begin
                  state_nx = state_t'(state + 4'd1);
                  addr_nx  = is_desc(state_nx) ? ADDR_LAST : '0;
               end else begin
                  addr_nx = is_desc(state) ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
               end
            end
         end
      endcase
      if (mismatch) begin
         state_nx = S_END;
         addr_nx  = '0;
         phase_nx = 1'b0;
      end

      // Port values for the op that will be on the SRAM port next cycle.
      act_nx  = is_march(state_nx);
      wr_nx   = act_nx && op_write(state_nx, phase_nx);
      cen_nx  = !act_nx;
      gwen_nx = !wr_nx;
      ben_nx  = {(DW/8){!wr_nx}};
      a_nx    = act_nx ? addr_nx : '0;
      d_nx    = wr_nx ? op_data(state_nx, phase_nx) : '0;
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cen_r     <= 1'b1;
         gwen_r    <= 1'b1;
         ben_r     <= '1;
         a_r       <= '0;
         d_r       <= '0;
         cmp_valid <= 1'b0;
         cmp_exp   <= '0;
         fail_r    <= 1'b0;
      end else begin
         cen_r     <= cen_nx;
         gwen_r    <= gwen_nx;
         ben_r     <= ben_nx;
         a_r       <= a_nx;
         d_r       <= d_nx;
         cmp_valid <= cur_read && !mismatch;
         cmp_exp   <= op_data(state, phase);
         if (start_run)
            fail_r <= 1'b0;
         else if (mismatch)
            fail_r <= 1'b1;
      end
   end

`ifdef SRAM_BIST_DIAG_EN
   logic [AW-1:0] cmp_addr, fail_addr_r;
   logic [DW-1:0] fail_data_r;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cmp_addr    <= '0;
         fail_addr_r <= '0;
         fail_data_r <= '0;
      end else begin
         cmp_addr <= addr;
         if (start_run) begin
            fail_addr_r <= '0;
            fail_data_r <= '0;
         end else if (mismatch && !fail_r) begin
            fail_addr_r <= cmp_addr;
            fail_data_r <= Q;
         end
      end
   end

   assign FAIL_ADDR = fail_addr_r;
   assign FAIL_DATA = fail_data_r;
`else
   assign FAIL_ADDR = '0;
   assign FAIL_DATA = '0;
`endif

   // The op issued in the mismatch cycle is dropped so the aborted run leaves no extra access.
   assign CEN  = cen_r | mismatch;
   assign GWEN = gwen_r;
   assign BEN  = ben_r;
   assign A    = a_r;
   assign D    = d_r;
   assign BUSY = is_march(state) || (state == S_FLUSH);
   assign DONE = (state == S_END);
   assign FAIL = fail_r;

endmodule

// File: tb/tb_sram_sp_bist_ctrl.sv
// tb/tb_sram_sp_bist_ctrl.sv - scoreboard bench for sram_sp_bist_ctrl with a behavioural SRAM and fault injection
module tb_sram_sp_bist_ctrl;

`ifdef SRAM_BIST_DIAG_EN
   localparam bit DIAG = 1'b1;
`else
   localparam bit DIAG = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic        busy, done, fail, cen, gwen;
   logic [3:0]  fail_addr, ben, a;
   logic [31:0] fail_data, d, q;

   logic [31:0] mem [16];
   logic [31:0] wr_word;
   int          fault_mode;
   logic [40:0] op_q [$];
   logic [40:0] exp_op;
   int          n_checks;
   int          n_errors;

   sram_sp_bist_ctrl #(.AW(4), .DW(32)) dut (
      .CLK(clk), .RESETn(resetn), .START(start),
      .BUSY(busy), .DONE(done), .FAIL(fail),
      .FAIL_ADDR(fail_addr), .FAIL_DATA(fail_data),
      .CEN(cen), .BEN(ben), .GWEN(gwen), .A(a), .D(d), .Q(q)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // SRAM with 1-cycle read latency; faults are applied at write time.
   always @(posedge clk) begin
      if (!cen) begin
         if (!gwen) begin
            wr_word = mem[a];
            for (int b = 0; b < 4; b++)
               if (!ben[b]) wr_word[b*8 +: 8] = d[b*8 +: 8];
            if (fault_mode == 1 && a == 4'd9) wr_word[5] = 1'b0;
            mem[a] <= wr_word;
            if (fault_mode == 2 && a == 4'd3) mem[4][0] <= ~mem[4][0];
         end else begin
            q <= mem[a];
         end
      end
   end

   always @(negedge clk) begin
      if (resetn && !cen) begin
         if (op_q.size() == 0) begin
            check_eq("op_extra", 64'(op_q.size()), 64'd1);
         end else begin
            exp_op = op_q.pop_front();
            check_eq("port_op", {23'd0, ~gwen, ben, a, d}, {23'd0, exp_op});
         end
      end
   end

   function automatic void push_op(input bit we, input int adr, input logic [31:0] bg);
      op_q.push_back({we, (we ? 4'h0 : 4'hF), 4'(adr), (we ? bg : 32'h0)});
   endfunction

   task automatic build_trace();
      op_q.delete();
      for (int i = 0; i < 16; i++) push_op(1, i, 32'h0);
      for (int i = 0; i < 16; i++) begin push_op(0, i, 0); push_op(1, i, 32'hFFFF_FFFF); end
      for (int i = 0; i < 16; i++) begin push_op(0, i, 0); push_op(1, i, 32'h0); end
      for (int i = 15; i >= 0; i--) begin push_op(0, i, 0); push_op(1, i, 32'hFFFF_FFFF); end
      for (int i = 15; i >= 0; i--) begin push_op(0, i, 0); push_op(1, i, 32'h0); end
      for (int i = 0; i < 16; i++) push_op(0, i, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_fail"}, fail, 0);
      check_eq({tag, "_fail_addr"}, fail_addr, 0);
      check_eq({tag, "_fail_data"}, fail_data, 0);
      check_eq({tag, "_port"}, {cen, gwen, ben, a, d}, {1'b1, 1'b1, 4'hF, 4'h0, 32'h0});
   endtask

   task automatic start_run(input bit hold);
      build_trace();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      check_eq("busy_rise", busy, 1);
   endtask

   task automatic wait_done(input int exp_busy, input logic exp_fail, input logic [3:0] exp_addr,
                            input logic [31:0] exp_data, input int exp_remain);
      int   busy_cnt = 0;
      int   cyc = 0;
      logic last_cen = 1'b0;
      while (!done && cyc < 400) begin
         if (busy) begin
            busy_cnt++;
            last_cen = cen;
         end
         cyc++;
         @(negedge clk);
      end
      check_eq("done", done, 1);
      check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
      check_eq("busy_low_at_done", busy, 0);
      check_eq("fail", fail, exp_fail);
      check_eq("fail_addr", fail_addr, exp_addr);
      check_eq("fail_data", fail_data, exp_data);
      check_eq("cen_last_busy", last_cen, 1);
      check_eq("ops_left", 64'(op_q.size()), 64'(exp_remain));
      op_q.delete();
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      fault_mode = 0;
      resetn     = 1'b0;
      start      = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      resetn = 1'b1;

      // Clean run.
      start_run(0);
      wait_done(161, 0, 4'd0, 32'h0, 0);

      // Stuck-at-0 on bit 5 of address 9: caught at the M2 read (op 66).
      fault_mode = 1;
      start_run(0);
      wait_done(68, 1, DIAG ? 4'd9 : 4'd0, DIAG ? 32'hFFFF_FFDF : 32'h0, 93);

      // Coupling: write to 3 flips bit 0 of 4, caught at the M1 read of 4 (op 24).
      fault_mode = 2;
      start_run(0);
      wait_done(26, 1, DIAG ? 4'd4 : 4'd0, DIAG ? 32'h0000_0001 : 32'h0, 135);

      // Asynchronous reset in M2, then a clean run.
      fault_mode = 0;
      start_run(0);
      repeat (55) @(negedge clk);
      resetn = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      @(negedge clk);
      resetn = 1'b1;
      op_q.delete();
      start_run(0);
      wait_done(161, 0, 4'd0, 32'h0, 0);

      // START held: one failing run, then a restart that clears FAIL state.
      fault_mode = 1;
      start_run(1);
      wait_done(68, 1, DIAG ? 4'd9 : 4'd0, DIAG ? 32'hFFFF_FFDF : 32'h0, 93);
      fault_mode = 0;
      build_trace();
      @(negedge clk);
      check_eq("restart_busy", busy, 1);
      check_eq("restart_fail", fail, 0);
      check_eq("restart_fail_addr", fail_addr, 0);
      check_eq("restart_fail_data", fail_data, 0);
      start = 1'b0;
      wait_done(161, 0, 4'd0, 32'h0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sram_sp_bist_ctrl.md
# sram_sp_bist_ctrl

March C- built-in self-test controller for the single-port byte-enabled SRAM macro wrapper. It acts as the initiator on the SRAM port: it drives chip-enable, byte-enables, global write-enable, address and write data, and checks read data. It sits beside the SoC bus-to-SRAM path behind a 2:1 port mux that `BUSY` selects. It reports pass/fail, and optionally the first failing location.

## Interface
- `AW`, 14, address width; depth = 2^AW words
- `DW`, 32, data width; must be a multiple of 8; byte lanes = DW/8

- `CLK` input 1: clock, shared with the SRAM
- `RESETn` input 1: asynchronous, active-low reset
- `START` input 1: level-sampled; a 1 in IDLE or END starts a run
- `BUSY` output 1: high while the controller owns the SRAM port; selects the mux
- `DONE` output 1: high in END
- `FAIL` output 1: valid when `DONE`=1; 1 means a mismatch was detected
- `FAIL_ADDR` output AW: address of the first mismatching read
- `FAIL_DATA` output DW: `Q` captured at the first mismatch
- `CEN` output 1: SRAM chip enable, active low
- `BEN` output DW/8: byte enables, active low; each bit expands to 8 SRAM WEN bits in the wrapper
- `GWEN` output 1: global write enable, active low
- `A` output AW: SRAM address
- `D` output DW: SRAM write data
- `Q` input DW: SRAM read data, valid one cycle after a read is issued

## Operation
- States: IDLE, M0..M5, FLUSH, END.
- Background values:
  - B0 = all zeros
  - B1 = all ones
- March elements, with per-address operations issued in the order listed:
  - M0 ascending: w B0
  - M1 ascending: r B0, w B1
  - M2 ascending: r B1, w B0
  - M3 descending: r B0, w B1
  - M4 descending: r B1, w B0
  - M5 ascending: r B0
- Operation encoding on the port:
  - write: `CEN`=0, `GWEN`=0, `BEN`=all 0, `D`=background
  - read: `CEN`=0, `GWEN`=1, `BEN`=all 1, `D`=0
- Idle port values (IDLE, FLUSH, END): `CEN`=1, `GWEN`=1, `BEN`=all 1, `A`=0, `D`=0.
- One SRAM operation is issued per cycle, with no bubbles between elements.
- Addressing:
  - Ascending elements start at 0; descending elements start at 2^AW-1.
  - The address counter is AW bits. The last address of an element is detected explicitly; there is no reliance on wrap-around.
- Transitions:
  - IDLE→M0 when `START`=1.
  - Mk→Mk+1 after the final operation at the last address.
  - M5→FLUSH after the last read.
  - FLUSH→END.
  - END→M0 when `START`=1.
  - `START` is ignored in M0..FLUSH.
- Compare stage:
  - Each read registers a compare-valid flag and its expected value and address.
  - In the next cycle, `Q` is compared against the expected value.
  - FLUSH exists only to compare the final M5 read.
- On the first mismatch:
  - `FAIL` is set and is sticky until the next START.
  - The operation issued in the mismatch cycle is suppressed (`CEN` forced to 1 combinationally).
  - The next state is END (abort).
- `FAIL` is cleared on the START that leaves IDLE or END.
- `BUSY` = 1 in M0..FLUSH.
- `DONE` = 1 in END only.
- Reset mid-run: the state returns to IDLE immediately, all outputs take their reset values, and the SRAM contents are undefined.

## Timing
- Reset values:
  - state IDLE
  - `BUSY`=0, `DONE`=0, `FAIL`=0
  - `FAIL_ADDR`=0, `FAIL_DATA`=0
  - `CEN`=1, `GWEN`=1, `BEN`=all 1, `A`=0, `D`=0
- All SRAM port outputs are registered, except the `CEN` suppression on mismatch.
- `START` sampled high at edge t: the first M0 write is on the port in cycle t+1, and `BUSY` rises in the same cycle.
- Passing run: 10·2^AW operation cycles plus 1 FLUSH cycle. `DONE` rises 10·2^AW+2 cycles after the START edge.
- Failing run: `DONE` rises in the cycle after the mismatch compare cycle.
- Read at cycle t: `Q` is compared at cycle t+1.

## Configuration
- `SRAM_BIST_DIAG_EN` defined:
  - `FAIL_ADDR` and `FAIL_DATA` are loaded on the first mismatch only.
  - They hold their values until the next START, which clears them to 0.
- `SRAM_BIST_DIAG_EN` not defined:
  - Both ports are driven constant 0 and their registers are not implemented.
  - `FAIL` behaviour is unchanged.

## Test plan
All scenarios use AW=4 and DW=32 with a behavioural SRAM model with a 1-cycle read latency.
- Clean run: pulse `START` → `BUSY` is high for 161 cycles, then `DONE`=1 and `FAIL`=0. The port trace shows 16 writes of 0, then r0/w1 pairs at 0..15, and M3 addresses running 15..0.
- Stuck-at-0, bit 5 of address 9: `FAIL`=1 at the M2 read of address 9.
  - With `SRAM_BIST_DIAG_EN`: `FAIL_ADDR`=9 and `FAIL_DATA`=32'hFFFF_FFDF.
  - The cycle after the mismatch has `CEN`=1.
- Coupling fault, a write to address 3 flips address 4 bit 0: `FAIL`=1 with `FAIL_ADDR`=4.
- `RESETn` asserted low during M2 → all outputs return to their reset values in the same cycle. A new START then gives a clean 161-cycle pass.
- `START` held high through a run → exactly one run, no restart mid-run. After `DONE`, the still-high `START` begins a second run in which `FAIL` and the FAIL_* registers are cleared.
- Build without `SRAM_BIST_DIAG_EN` and repeat the stuck-at scenario → `FAIL`=1, `FAIL_ADDR`=0, `FAIL_DATA`=0.
